// File: rtl/ex_pkg.sv
// Shared definitions for the execute-operand stage: ALU opcodes and operand selects.
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  typedef enum logic [1:0] {
    SEL_A_RS1  = 2'b00,
    SEL_A_PC   = 2'b01,
    SEL_A_ZERO = 2'b10
  } sel_a_e;

  typedef enum logic {
    SEL_B_RS2 = 1'b0,
    SEL_B_IMM = 1'b1
  } sel_b_e;

endpackage

// File: rtl/ex_operand_stage_fwd_select.sv
// Writeback-to-execute bypass for one source register; x0 is never bypassed.
module fwd_select
  import ex_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic [RegAddrWidth-1:0] addr,
  input  logic [DataWidth-1:0]    rf_data,
  input  logic                    wb_valid,
  input  logic [RegAddrWidth-1:0] wb_rd_addr,
  input  logic [DataWidth-1:0]    wb_data,
  output logic [DataWidth-1:0]    data
);

  logic hit_s;

  assign hit_s = wb_valid && (wb_rd_addr != {RegAddrWidth{1'b0}}) && (wb_rd_addr == addr);

  // Select the writeback value when it targets this source register.
  always_comb begin
    data = rf_data;
    if (hit_s) begin
      data = wb_data;
    end else begin
      data = rf_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX one-entry stage feeding the RV32I ALU, with writeback forwarding at capture and during hold.
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    id_valid,
  output logic                    id_ready,
  input  logic [DataWidth-1:0]    id_pc,
  input  logic [DataWidth-1:0]    id_rs1_data,
  input  logic [DataWidth-1:0]    id_rs2_data,
  input  logic [DataWidth-1:0]    id_imm,
  input  logic [RegAddrWidth-1:0] id_rs1_addr,
  input  logic [RegAddrWidth-1:0] id_rs2_addr,
  input  logic [RegAddrWidth-1:0] id_rd_addr,
  input  logic                    id_reg_write,
  input  logic [3:0]              id_alu_control,
  input  logic [1:0]              id_sel_a,
  input  logic                    id_sel_b,
  input  logic                    wb_valid,
  input  logic [RegAddrWidth-1:0] wb_rd_addr,
  input  logic [DataWidth-1:0]    wb_data,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [DataWidth-1:0]    operand_a,
  output logic [DataWidth-1:0]    operand_b,
  output logic [3:0]              alu_control,
  output logic [RegAddrWidth-1:0] ex_rd_addr,
  output logic                    ex_reg_write,
  output logic [DataWidth-1:0]    ex_pc
);

  logic                    valid_r;
  logic [DataWidth-1:0]    rs1_r;
  logic [DataWidth-1:0]    rs2_r;
  logic [DataWidth-1:0]    pc_r;
  logic [DataWidth-1:0]    imm_r;
  logic [RegAddrWidth-1:0] rs1_addr_r;
  logic [RegAddrWidth-1:0] rs2_addr_r;
  logic [RegAddrWidth-1:0] rd_r;
  logic                    reg_write_r;
  logic [3:0]              alu_r;
  logic [1:0]              sel_a_r;
  logic                    sel_b_r;

  logic                    id_ready_s;
  logic                    capture_s;
  logic                    hold_s;
  logic [DataWidth-1:0]    cap_rs1_s;
  logic [DataWidth-1:0]    cap_rs2_s;
  logic [DataWidth-1:0]    hold_rs1_s;
  logic [DataWidth-1:0]    hold_rs2_s;
  logic [DataWidth-1:0]    operand_a_s;
  logic [DataWidth-1:0]    operand_b_s;

  assign id_ready_s = !flush_i && (!valid_r || ex_ready);
  assign capture_s  = id_valid && id_ready_s;
  // A held instruction that is not leaving this cycle keeps snooping writeback.
  assign hold_s     = valid_r && !ex_ready;

  fwd_select #(.DataWidth(DataWidth), .RegAddrWidth(RegAddrWidth)) u_cap_rs1 (
    .addr(id_rs1_addr), .rf_data(id_rs1_data), .wb_valid(wb_valid),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .data(cap_rs1_s)
  );

  fwd_select #(.DataWidth(DataWidth), .RegAddrWidth(RegAddrWidth)) u_cap_rs2 (
    .addr(id_rs2_addr), .rf_data(id_rs2_data), .wb_valid(wb_valid),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .data(cap_rs2_s)
  );

  fwd_select #(.DataWidth(DataWidth), .RegAddrWidth(RegAddrWidth)) u_hold_rs1 (
    .addr(rs1_addr_r), .rf_data(rs1_r), .wb_valid(wb_valid),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .data(hold_rs1_s)
  );

  fwd_select #(.DataWidth(DataWidth), .RegAddrWidth(RegAddrWidth)) u_hold_rs2 (
    .addr(rs2_addr_r), .rf_data(rs2_r), .wb_valid(wb_valid),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .data(hold_rs2_s)
  );

  // EMPTY/FULL occupancy; flush wins over capture and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (capture_s) begin
      valid_r <= 1'b1;
    end else if (ex_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload capture with bypass, and refresh of held sources from writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_r       <= {DataWidth{1'b0}};
      rs2_r       <= {DataWidth{1'b0}};
      pc_r        <= {DataWidth{1'b0}};
      imm_r       <= {DataWidth{1'b0}};
      rs1_addr_r  <= {RegAddrWidth{1'b0}};
      rs2_addr_r  <= {RegAddrWidth{1'b0}};
      rd_r        <= {RegAddrWidth{1'b0}};
      reg_write_r <= 1'b0;
      alu_r       <= ALU_ADD;
      sel_a_r     <= SEL_A_RS1;
      sel_b_r     <= SEL_B_RS2;
    end else if (capture_s) begin
      rs1_r       <= cap_rs1_s;
      rs2_r       <= cap_rs2_s;
      pc_r        <= id_pc;
      imm_r       <= id_imm;
      rs1_addr_r  <= id_rs1_addr;
      rs2_addr_r  <= id_rs2_addr;
      rd_r        <= id_rd_addr;
      reg_write_r <= id_reg_write;
      alu_r       <= id_alu_control;
      sel_a_r     <= id_sel_a;
      sel_b_r     <= id_sel_b;
    end else if (hold_s) begin
      rs1_r <= hold_rs1_s;
      rs2_r <= hold_rs2_s;
    end else begin
      rs1_r <= rs1_r;
      rs2_r <= rs2_r;
    end
  end

  // Operand muxes work off stored state so they are valid alongside ex_valid.
  always_comb begin
    operand_a_s = rs1_r;
    operand_b_s = rs2_r;
    case (sel_a_r)
      SEL_A_RS1:  operand_a_s = rs1_r;
      SEL_A_PC:   operand_a_s = pc_r;
      SEL_A_ZERO: operand_a_s = {DataWidth{1'b0}};
      default:    operand_a_s = rs1_r;
    endcase
    case (sel_b_r)
      SEL_B_RS2: operand_b_s = rs2_r;
      SEL_B_IMM: operand_b_s = imm_r;
      default:   operand_b_s = rs2_r;
    endcase
  end

  assign id_ready     = id_ready_s;
  assign ex_valid     = valid_r;
  assign operand_a    = operand_a_s;
  assign operand_b    = operand_b_s;
  assign alu_control  = alu_r;
  assign ex_rd_addr   = rd_r;
  assign ex_reg_write = reg_write_r && valid_r;
  assign ex_pc        = pc_r;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed vectors, expected results queued at issue.
module tb_ex_operand_stage;
  import ex_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write;
  logic [3:0]  id_alu_control;
  logic [1:0]  id_sel_a;
  logic        id_sel_b;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_control;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic [31:0] ex_pc;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;

  ex_operand_stage #(.DataWidth(32), .RegAddrWidth(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_alu_control(id_alu_control),
    .id_sel_a(id_sel_a), .id_sel_b(id_sel_b),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .operand_a(operand_a), .operand_b(operand_b), .alu_control(alu_control),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_pc(ex_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
                      input logic [31:0] imm, input logic [4:0] rs1a, input logic [4:0] rs2a,
                      input logic [4:0] rd, input logic rw, input logic [3:0] alu,
                      input logic [1:0] sa, input logic sb);
    id_valid = 1'b1; id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
    id_rs1_addr = rs1a; id_rs2_addr = rs2a; id_rd_addr = rd; id_reg_write = rw;
    id_alu_control = alu; id_sel_a = sa; id_sel_b = sb;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] alu,
                      input logic [4:0] rd, input logic rw, input logic [31:0] pc);
    exp_t e;
    e.a = a; e.b = b; e.alu = alu; e.rd = rd; e.rw = rw; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted ALU transfer is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        popped++;
        chk("mon_operand_a", operand_a, e.a);
        chk("mon_operand_b", operand_b, e.b);
        chk("mon_alu_control", {28'd0, alu_control}, {28'd0, e.alu});
        chk("mon_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
        chk("mon_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
        chk("mon_pc", ex_pc, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
    id_pc = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0; id_reg_write = 1'b0;
    id_alu_control = 4'd0; id_sel_a = 2'd0; id_sel_b = 1'b0;
    wb_valid = 1'b0; wb_rd_addr = 5'd0; wb_data = 32'd0;
    #12;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_operand_a", operand_a, 32'd0);
    chk("rst_operand_b", operand_b, 32'd0);
    chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
    chk("rst_rd_addr", {27'd0, ex_rd_addr}, 32'd0);
    chk("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Plain capture: rs1=5, rs2=7, ADD.
    ex_ready = 1'b1;
    send(32'h40, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd10, 1'b1, ALU_ADD, 2'b00, 1'b0);
    push(32'd5, 32'd7, ALU_ADD, 5'd10, 1'b1, 32'h40);
    step();
    chk("cap_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("cap_operand_a", operand_a, 32'd5);

    // Capture forwarding from writeback onto rs1.
    wb_valid = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'hDEAD;
    send(32'h44, 32'h1111, 32'h22, 32'd0, 5'd3, 5'd4, 5'd11, 1'b1, ALU_SUB, 2'b00, 1'b0);
    push(32'hDEAD, 32'h22, ALU_SUB, 5'd11, 1'b1, 32'h44);
    step();

    // Writeback to x0 must not forward into an rs1=x0 read.
    wb_rd_addr = 5'd0;
    send(32'h48, 32'h3333, 32'h44, 32'd0, 5'd0, 5'd5, 5'd12, 1'b1, ALU_SLL, 2'b00, 1'b0);
    push(32'h3333, 32'h44, ALU_SLL, 5'd12, 1'b1, 32'h48);
    step();

    // Instruction that will stall and pick up a rs2 writeback while held.
    wb_valid = 1'b0;
    send(32'h4C, 32'hA, 32'h55, 32'd0, 5'd6, 5'd4, 5'd13, 1'b1, ALU_XOR, 2'b00, 1'b0);
    push(32'hA, 32'h1234, ALU_XOR, 5'd13, 1'b1, 32'h4C);
    step();
    ex_ready = 1'b0;
    send(32'h100, 32'h77, 32'h88, 32'h10, 5'd7, 5'd8, 5'd14, 1'b0, ALU_OR, 2'b01, 1'b1);
    push(32'h100, 32'h10, ALU_OR, 5'd14, 1'b0, 32'h100);
    #1;
    chk("stall_id_ready_1", {31'd0, id_ready}, 32'd0);
    step();
    chk("stall_id_ready_2", {31'd0, id_ready}, 32'd0);
    chk("stall_operand_b_pre", operand_b, 32'h55);
    step();
    chk("stall_id_ready_3", {31'd0, id_ready}, 32'd0);
    wb_valid = 1'b1; wb_rd_addr = 5'd4; wb_data = 32'h1234;
    step();
    wb_valid = 1'b0;
    chk("stall_operand_b_fwd", operand_b, 32'h1234);
    chk("stall_id_ready_4", {31'd0, id_ready}, 32'd0);
    ex_ready = 1'b1;
    step();

    // Back-to-back stream of four.
    for (int k = 0; k < 4; k++) begin
      chk("stream_id_ready", {31'd0, id_ready}, 32'd1);
      send(32'h200 + 32'(k * 4), 32'h100 + 32'(k), 32'h200 + 32'(k), 32'd0,
           5'd9, 5'd10, 5'(k + 1), 1'b1, 4'(k), 2'b00, 1'b0);
      push(32'h100 + 32'(k), 32'h200 + 32'(k), 4'(k), 5'(k + 1), 1'b1, 32'h200 + 32'(k * 4));
      step();
    end
    id_valid = 1'b0;
    step();
    chk("drain_ex_valid", {31'd0, ex_valid}, 32'd0);

    // Flush with a held instruction and a new one on offer.
    ex_ready = 1'b0;
    send(32'h300, 32'h1, 32'h2, 32'd0, 5'd1, 5'd2, 5'd20, 1'b1, ALU_AND, 2'b00, 1'b0);
    step();
    chk("preflush_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("preflush_reg_write", {31'd0, ex_reg_write}, 32'd1);
    flush_i = 1'b1;
    send(32'h304, 32'h3, 32'h4, 32'd0, 5'd1, 5'd2, 5'd21, 1'b1, ALU_ADD, 2'b00, 1'b0);
    #1;
    chk("flush_id_ready", {31'd0, id_ready}, 32'd0);
    step();
    flush_i = 1'b0; id_valid = 1'b0;
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_reg_write", {31'd0, ex_reg_write}, 32'd0);
    step();
    chk("flush_no_capture", {31'd0, ex_valid}, 32'd0);

    // Zero operand A select.
    ex_ready = 1'b1;
    send(32'h400, 32'h999, 32'h5, 32'd0, 5'd1, 5'd2, 5'd0, 1'b0, ALU_LUI, 2'b10, 1'b0);
    push(32'd0, 32'h5, ALU_LUI, 5'd0, 1'b0, 32'h400);
    step();

    // Reset while an instruction is held.
    send(32'h500, 32'h13, 32'h14, 32'd0, 5'd1, 5'd2, 5'd15, 1'b1, ALU_AND, 2'b00, 1'b0);
    step();
    ex_ready = 1'b0; id_valid = 1'b0;
    chk("hold_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("hold_operand_a", operand_a, 32'h13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("midrst_operand_a", operand_a, 32'd0);
    chk("midrst_operand_b", operand_b, 32'd0);
    chk("midrst_alu_control", {28'd0, alu_control}, 32'd0);
    chk("midrst_rd_addr", {27'd0, ex_rd_addr}, 32'd0);
    chk("midrst_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("midrst_pc", ex_pc, 32'd0);
    chk("transfers_seen", 32'(popped), 32'd10);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the RV32I ALU.
- Accepts decoded instructions from decode over a valid/ready handshake and holds them in a one-entry register.
- Applies writeback-to-execute forwarding, both at capture and while an instruction is held.
- Drives operand_a, operand_b and alu_control into the ALU, plus destination metadata for the downstream stage.

Parameters:
- DataWidth, 32, width of register, PC and immediate data.
- RegAddrWidth, 5, width of register-file addresses.

Ports:
- clk  input  1  single clock for the block.
- rst_n  input  1  asynchronous, active-low reset.
- flush_i  input  1  squash the held instruction (branch/jump redirect).
- id_valid  input  1  decode presents an instruction.
- id_ready  output  1  stage can accept an instruction this cycle.
- id_pc  input  DataWidth  instruction PC.
- id_rs1_data  input  DataWidth  register-file read data for rs1.
- id_rs2_data  input  DataWidth  register-file read data for rs2.
- id_imm  input  DataWidth  sign-extended immediate.
- id_rs1_addr  input  RegAddrWidth  rs1 address.
- id_rs2_addr  input  RegAddrWidth  rs2 address.
- id_rd_addr  input  RegAddrWidth  destination address.
- id_reg_write  input  1  instruction writes rd.
- id_alu_control  input  4  ALU operation code.
- id_sel_a  input  2  operand A select: 00 rs1, 01 pc, 10 zero, 11 rs1.
- id_sel_b  input  1  operand B select: 0 rs2, 1 imm.
- wb_valid  input  1  writeback is writing wb_rd_addr this cycle.
- wb_rd_addr  input  RegAddrWidth  writeback destination.
- wb_data  input  DataWidth  writeback value.
- ex_valid  output  1  held instruction valid toward the ALU/downstream.
- ex_ready  input  1  downstream consumes the held instruction this cycle.
- operand_a  output  DataWidth  ALU operand A.
- operand_b  output  DataWidth  ALU operand B.
- alu_control  output  4  ALU operation code.
- ex_rd_addr  output  RegAddrWidth  held destination address.
- ex_reg_write  output  1  held write enable; 0 whenever ex_valid is 0.
- ex_pc  output  DataWidth  held PC.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: ex_valid=0, alu_control=0000, operand_a=0, operand_b=0, ex_rd_addr=0, ex_reg_write=0, ex_pc=0; all payload registers cleared to 0.
- States: EMPTY (ex_valid=0) and FULL (ex_valid=1).
- id_ready = !flush_i && (!ex_valid || ex_ready). This is combinational; there is no bubble on back-to-back transfers.
- Capture: on id_valid && id_ready, the payload is registered and ex_valid=1 on the next edge. Latency from decode handshake to ALU inputs is 1 cycle.
- Consume without capture: on ex_valid && ex_ready && !(id_valid && id_ready), ex_valid goes to 0.
- Flush: flush_i forces ex_valid=0 on the next edge, regardless of ex_ready or id_valid. Flush has priority over capture and hold. Nothing is captured in a flush cycle.
- Operand registers: the stage stores rs1 and rs2 values, pc, imm and the selects. operand_a and operand_b are combinational muxes of the stored values, so they are valid in the same cycle as ex_valid.
- Capture forwarding: if wb_valid && wb_rd_addr!=0 && wb_rd_addr==id_rs1_addr, the stored rs1 value is wb_data; otherwise it is id_rs1_data. rs2 follows the same rule. When both source addresses match, both are forwarded.
- Hold forwarding: while FULL and not consumed, a writeback with wb_valid && wb_rd_addr!=0 matching a held rs address overwrites the stored value on the next edge.
- x0 rule: address 0 is never forwarded.
- Payload when EMPTY: operand and alu_control outputs keep their last values and are ignored. ex_reg_write is forced to 0.
- Width rules: all data paths are DataWidth wide; no arithmetic is performed in this block.
- Reset mid-operation: asynchronous clear to the reset values above. Any in-flight instruction is dropped.

Decomposition:
- Shared package ex_pkg holds:
  - ALU op constants ALU_ADD=0000, ALU_SUB=0001, ALU_SLL=0010, ALU_SLT=0011, ALU_SLTU=0100, ALU_XOR=0101, ALU_SRL=0110, ALU_SRA=0111, ALU_OR=1000, ALU_AND=1001, ALU_LUI=1111.
  - Typedef sel_a_e {SEL_A_RS1, SEL_A_PC, SEL_A_ZERO}.
  - Typedef sel_b_e {SEL_B_RS2, SEL_B_IMM}.
- One sub-module, fwd_select: given address, register-file data and the writeback bus, returns the forwarded value. It is instantiated twice at capture and twice for hold.

Test Plan:
- Reset then id_valid with rs1=5, rs2=7, sel_a=00, sel_b=0, alu_control=0000 -> next cycle ex_valid=1, operand_a=5, operand_b=7, alu_control=0000.
- Capture with id_rs1_addr=3 while wb_valid=1, wb_rd_addr=3, wb_data=0xDEAD -> operand_a=0xDEAD; repeat with wb_rd_addr=0 -> operand_a=id_rs1_data.
- FULL with ex_ready=0 for 3 cycles, then wb writes rs2 address 4 with 0x1234 -> operand_b=0x1234 from next cycle; id_ready=0 throughout the stall.
- Back-to-back stream of 4 instructions with ex_ready=1 -> one instruction per cycle, in order, and id_ready stays 1.
- flush_i together with id_valid=1 and ex_valid=1 -> id_ready=0, ex_valid=0 next cycle, new instruction not captured, and ex_reg_write=0.
- Capture with sel_a=01, sel_b=1, pc=0x100, imm=0x10 -> operand_a=0x100, operand_b=0x10. Capture with sel_a=10 -> operand_a=0. Assert rst_n low mid-hold -> all outputs are 0 immediately.
